// File: rtl/seg_scan_ctrl.sv
// Eight-digit 7-segment scan controller: blank/drive digit sequencing, active-low anode
// enables and a double-buffered display word that is committed only at frame boundaries.

module mux8_4 (
  input  logic [31:0] din,
  input  logic [2:0]  sel,
  output logic [3:0]  dout
);

  always_comb begin
    dout = 4'h0;
    unique case (sel)
      3'd0: dout = din[3:0];
      3'd1: dout = din[7:4];
      3'd2: dout = din[11:8];
      3'd3: dout = din[15:12];
      3'd4: dout = din[19:16];
      3'd5: dout = din[23:20];
      3'd6: dout = din[27:24];
      3'd7: dout = din[31:28];
      default: dout = 4'h0;
    endcase
  end

endmodule

module seg_scan_ctrl #(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [7:0]  digit_mask,
  output logic [2:0]  select,
  output logic [3:0]  nibble,
  output logic [7:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned MaxCycles = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
  localparam logic [CntW-1:0] DriveLast = CntW'(DIGIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     active;
  logic [31:0]     pending;
  logic            pend_valid;
  logic            drive_end;
  logic            wrap;
  logic            commit;

  assign drive_end = (state == StDrive) && (cnt == DriveLast);
  assign wrap      = drive_end && (select == 3'd7);
  // Commit in IDLE unconditionally, or at a frame wrap that is not being cut short by en=0.
  assign commit    = (pend_valid || load) && ((state == StIdle) || (en && wrap));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= '0;
      select     <= 3'd0;
      frame_done <= 1'b0;
      active     <= 32'h0;
      pending    <= 32'h0;
      pend_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (load) begin
        pending <= din;
      end
      // A load coinciding with a commit bypasses the pending buffer.
      if (commit) begin
        active     <= load ? din : pending;
        pend_valid <= 1'b0;
      end else if (load) begin
        pend_valid <= 1'b1;
      end

      if (!en) begin
        state  <= StIdle;
        cnt    <= '0;
        select <= 3'd0;
      end else begin
        unique case (state)
          StIdle: begin
            state  <= StBlank;
            cnt    <= '0;
            select <= 3'd0;
          end
          StBlank: begin
            if (cnt == BlankLast) begin
              state <= StDrive;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          StDrive: begin
            if (drive_end) begin
              state      <= StBlank;
              cnt        <= '0;
              select     <= select + 3'd1;
              frame_done <= (select == 3'd7);
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          default: begin
            state <= StIdle;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Mask is applied combinationally so a change darkens the digit within the current cycle.
  always_comb begin
    an_n = 8'hFF;
    if ((state == StDrive) && digit_mask[select]) begin
      an_n[select] = 1'b0;
    end
  end

  mux8_4 u_mux (
    .din  (active),
    .sel  (select),
    .dout (nibble)
  );

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: the stimulus thread queues the expected per-cycle outputs,
// a negedge monitor pops and compares them.

module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [31:0] din;
  logic [7:0]  digit_mask;
  logic [2:0]  select;
  logic [3:0]  nibble;
  logic [7:0]  an_n;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] an;
    logic [2:0] sel;
    logic [3:0] nib;
    logic       fd;
    int         tag;
  } exp_t;

  exp_t sb[$];

  seg_scan_ctrl #(
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .din        (din),
    .digit_mask (digit_mask),
    .select     (select),
    .nibble     (nibble),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s [%0d]: got %h, want %h", name, tag, act, req);
    end
  endtask

  task automatic push(input logic [7:0] an, input logic [2:0] sel, input logic [3:0] nib,
                      input logic fd, input int tag);
    exp_t e;
    e.an  = an;
    e.sel = sel;
    e.nib = nib;
    e.fd  = fd;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Expected outputs for cycle i of a scan that started with digit 0 blank at i=0.
  function automatic exp_t scan_exp(input int i, input logic [31:0] word, input logic [7:0] mask);
    exp_t e;
    int d;
    int ph;
    d     = (i / 6) % 8;
    ph    = i % 6;
    e.sel = d[2:0];
    e.nib = word[4*d +: 4];
    e.an  = ((ph < 2) || !mask[d]) ? 8'hFF : ~(8'h01 << d);
    e.fd  = (i > 0) && (i % 48 == 0);
    e.tag = i;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("an_n", e.tag, 32'(an_n), 32'(e.an));
      check("select", e.tag, 32'(select), 32'(e.sel));
      check("nibble", e.tag, 32'(nibble), 32'(e.nib));
      check("frame_done", e.tag, 32'(frame_done), 32'(e.fd));
    end
    check("an_n_one_low", 0, 32'($countones(~an_n) <= 1), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m_word;
    logic [7:0]  m_mask;

    rst_n      = 1'b0;
    en         = 1'b1;
    load       = 1'b0;
    din        = 32'h0;
    digit_mask = 8'hFF;

    // Reset acts before any clock edge.
    #1;
    check("rst_an_n", -1, 32'(an_n), 32'hFF);
    check("rst_select", -1, 32'(select), 32'h0);
    check("rst_nibble", -1, 32'(nibble), 32'h0);
    check("rst_frame_done", -1, 32'(frame_done), 32'h0);

    repeat (2) begin
      tick();
      push(8'hFF, 3'd0, 4'h0, 1'b0, -2);
    end
    en = 1'b0;
    #2 rst_n = 1'b1;
    repeat (4) begin
      tick();
      push(8'hFF, 3'd0, 4'h0, 1'b0, -3);
    end

    // Load in IDLE, then enable.
    load = 1'b1;
    din  = 32'h76543210;
    tick();
    load = 1'b0;
    din  = 32'h0;
    push(8'hFF, 3'd0, 4'h0, 1'b0, -4);
    en = 1'b1;
    tick();

    m_word = 32'h76543210;
    m_mask = 8'hFF;
    for (int i = 0; i < 177; i++) begin
      if (i == 48) m_word = 32'hFFFFFFFF;
      if (i == 96) begin
        m_mask     = 8'hAA;
        digit_mask = 8'hAA;
      end
      if (i == 144) begin
        m_word     = 32'h89ABCDEF;
        m_mask     = 8'hFF;
        digit_mask = 8'hFF;
      end
      sb.push_back(scan_exp(i, m_word, m_mask));
      load = (i == 20) || (i == 100) || (i == 170);
      din  = (i == 20) ? 32'hFFFFFFFF : (i == 100) ? 32'h89ABCDEF :
             (i == 170) ? 32'h11111111 : 32'h0;
      if (i == 176) en = 1'b0;
      tick();
    end
    load = 1'b0;
    din  = 32'h0;

    // Disabled during digit 5: IDLE at once, pending word commits one edge later.
    push(8'hFF, 3'd0, 4'hF, 1'b0, -5);
    tick();
    push(8'hFF, 3'd0, 4'h1, 1'b0, -6);
    en = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      sb.push_back(scan_exp(i, 32'h11111111, 8'hFF));
      tick();
    end

    // Mid-DRIVE of digit 2, then reset between edges.
    check("pre_reset_an_n", 15, 32'(an_n), 32'hFB);
    #2 rst_n = 1'b0;
    #1;
    check("async_an_n", -7, 32'(an_n), 32'hFF);
    check("async_select", -7, 32'(select), 32'h0);
    check("async_nibble", -7, 32'(nibble), 32'h0);
    check("async_frame_done", -7, 32'(frame_done), 32'h0);
    en = 1'b0;
    tick();
    push(8'hFF, 3'd0, 4'h0, 1'b0, -8);
    #2 rst_n = 1'b1;
    repeat (3) begin
      tick();
      push(8'hFF, 3'd0, 4'h0, 1'b0, -9);
    end
    tick();

    check("queue_drained", 0, 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
